multi_edge_detector: RTL

//  Parametrised multi-channel edge detector; successor to the single-channel falling-edge detector.

---
 rtl/multi_edge_detector.sv | 134 +++++++++++++
 1 files changed

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector with optional input synchroniser, per-channel mode,
// one-cycle pulse, sticky flag and saturating edge counter per channel.
module multi_edge_detector #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       d_in,
    input  logic [2*WIDTH-1:0]     mode,
    input  logic [WIDTH-1:0]       clr,
    output logic [WIDTH-1:0]       edge_pulse,
    output logic [WIDTH-1:0]       edge_sticky,
    output logic [WIDTH*CNT_W-1:0] edge_cnt,
    output logic                   any_event
);

    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(SYNC_STAGES + 2);

    logic [WIDTH-1:0] w_samp;
    logic [WIDTH-1:0] r_prev;
    logic [ARM_W-1:0] r_arm;
    logic             w_armed;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_qual;
    logic [WIDTH-1:0] w_sticky_nxt;
    logic [WIDTH-1:0] r_pulse;
    logic [WIDTH-1:0] r_sticky;
    logic             r_any;
    logic [CNT_W-1:0] r_cnt     [WIDTH];
    logic [CNT_W-1:0] w_cnt_nxt [WIDTH];

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_samp = d_in;
        end else begin : g_sync
            logic [WIDTH-1:0] r_sync [SYNC_STAGES];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        r_sync[k] <= '0;
                    end
                end else begin
                    r_sync[0] <= d_in;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        r_sync[k] <= r_sync[k-1];
                    end
                end
            end
            assign w_samp = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // Shared warm-up counter: stops once the pipeline and prev hold real samples.
    assign w_armed = (r_arm == ARM_W'(ARM_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_arm  <= '0;
            r_prev <= '0;
        end else begin
            r_prev <= w_samp;
            if (!w_armed) begin
                r_arm <= r_arm + ARM_W'(1);
            end
        end
    end

    assign w_rise = w_samp & ~r_prev;
    assign w_fall = ~w_samp & r_prev;

    always_comb begin
        w_qual       = '0;
        w_sticky_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (mode[2*i +: 2])
                2'b01:   w_qual[i] = w_rise[i];
                2'b10:   w_qual[i] = w_fall[i];
                2'b11:   w_qual[i] = w_rise[i] | w_fall[i];
                default: w_qual[i] = 1'b0;
            endcase
            w_qual[i]       = w_qual[i] & w_armed;
            w_sticky_nxt[i] = (r_sticky[i] & ~clr[i]) | w_qual[i];
        end
    end

    // An edge coinciding with clr wins: count restarts at 1.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (w_qual[i]) begin
                if (clr[i]) begin
                    w_cnt_nxt[i] = CNT_W'(1);
                end else if (r_cnt[i] != {CNT_W{1'b1}}) begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end else if (clr[i]) begin
                w_cnt_nxt[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pulse  <= '0;
            r_sticky <= '0;
            r_any    <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_pulse  <= w_qual;
            r_sticky <= w_sticky_nxt;
            r_any    <= |w_sticky_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign edge_pulse  = r_pulse;
    assign edge_sticky = r_sticky;
    assign any_event   = r_any;

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_cnt
            assign edge_cnt[CNT_W*g +: CNT_W] = r_cnt[g];
        end
    endgenerate

endmodule
